// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_ID_W    = $clog2(DEFAULT_NUM_REQ);

  // Next requester index after idx, wrapping from n-1 back to 0
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  // First requester with req high, searching upward from rr_ptr with wrap
  always_comb begin
    int idx;
    gnt_onehot = '0;
    winner     = '0;
    any_req    = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[ID_W'(idx)]) begin
        any_req                  = 1'b1;
        winner                   = ID_W'(idx);
        gnt_onehot[ID_W'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter for the FIFO write port (optional FIFO_ARB_STATS_EN)
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 8,
  parameter int  MAX_BURST  = 4,
  parameter int  CNT_WIDTH  = 16,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic                          full,
`ifdef FIFO_ARB_STATS_EN
  input  logic                          stat_clr,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_beats,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          we,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          busy,
  output logic [ID_W-1:0]               active_id
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]     active_id_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_winner;
  logic                pick_any;
  logic [ID_W-1:0]     sel_id;
  logic                sel_last;
  logic [DATA_WIDTH-1:0] beat [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .gnt_onehot (pick_gnt),
    .winner     (pick_winner),
    .any_req    (pick_any)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_beat
    assign beat[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign sel_id   = (state_q == BURST) ? owner_q : pick_winner;
  assign sel_last = req_last[sel_id];

  // State register and arbitration bookkeeping
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      active_id  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      active_id  <= active_id_d;
    end
  end

  // Next state: grant ends on req_last or when the burst budget is used up
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    active_id_d = active_id;
    case (state_q)
      IDLE: begin
        if (we) begin
          active_id_d = pick_winner;
          if (sel_last || MAX_BURST == 1) begin
            rr_ptr_d = ID_W'(rr_wrap_inc(32'(pick_winner), NUM_REQ));
          end else begin
            state_d    = BURST;
            owner_d    = pick_winner;
            beat_cnt_d = BC_W'(1);
          end
        end
      end
      BURST: begin
        if (we) begin
          if (sel_last || beat_cnt_q == BC_W'(MAX_BURST - 1)) begin
            state_d    = IDLE;
            rr_ptr_d   = ID_W'(rr_wrap_inc(32'(owner_q), NUM_REQ));
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grant is held off by full and by reset so nothing leaks mid-reset
  always_comb begin
    gnt  = '0;
    busy = (state_q == BURST);
    if (!full && wrst_n) begin
      if (state_q == BURST) gnt[owner_q] = 1'b1;
      else if (pick_any)    gnt = pick_gnt;
    end
    we      = |(req & gnt);
    data_in = we ? beat[sel_id] : '0;
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [CNT_WIDTH-1:0] cnt_q;
    // Saturating per-requester accepted-beat counter; clear wins over count
    always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n)                                cnt_q <= '0;
      else if (stat_clr)                          cnt_q <= '0;
      else if (req[i] && gnt[i] && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
    end
    assign stat_beats[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`endif

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single FIFO write port (we / data_in) among NUM_REQ write-side requesters. All logic runs in the write clock domain.
- Supports packet bursts. A granted requester keeps the port until it asserts req_last or hits MAX_BURST beats, whichever comes first.
- Sits between the requesters and the FIFO write-pointer handler and memory. It respects full, so no beat is ever dropped.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, width of one data beat; matches the FIFO memory
- MAX_BURST, 4, maximum beats per grant before forced rotation (>=1)
- CNT_WIDTH, 16, width of the optional statistics counters

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  marks the final beat of a packet; sampled only on an accepted beat
- full  in  1  FIFO full flag from the write-pointer handler
- gnt  out  NUM_REQ  per-requester ready; a beat transfers when req[i] & gnt[i]
- we  out  1  FIFO write enable
- data_in  out  DATA_WIDTH  FIFO write data
- busy  out  1  high while a multi-beat burst holds the port
- active_id  out  $clog2(NUM_REQ)  registered index of the current or last owner

Behaviour:
- Reset: wclk and wrst_n as above; polarity and synchronicity are fixed. While wrst_n is low, all of the following hold, and reset is asynchronous, so they apply even mid-burst:
  - state = IDLE, rr_ptr = 0, beat_cnt = 0, active_id = 0, busy = 0
  - gnt = 0 and we = 0
  - a partially sent packet is abandoned
- gnt, we and data_in are combinational from the registered state plus req and full. This gives zero-cycle latency from req to write.
- A beat is accepted only when !full. With full = 1, all gnt = 0, we = 0, and state, owner and beat_cnt hold.
- we = |(req & gnt). data_in = req_data slice of the granted requester, or 0 when we = 0.
- State IDLE:
  - When !full and any req is high, the winner is the first requester with req high, searching from rr_ptr upward and wrapping at NUM_REQ-1 -> 0. gnt[winner] = 1 in the same cycle.
  - On the accepted beat, if req_last[winner] = 1 or MAX_BURST == 1:
    - stay in IDLE, rr_ptr <= winner+1 (mod NUM_REQ), active_id <= winner.
  - Otherwise go to BURST: owner <= winner, active_id <= winner, beat_cnt <= 1.
- State BURST:
  - gnt[owner] = !full; every other gnt = 0, even if the owner drops req. Packet lock: the owner may insert bubbles.
  - On each accepted beat beat_cnt increments.
  - If req_last[owner] = 1, or beat_cnt == MAX_BURST-1 before the increment: go to IDLE, rr_ptr <= owner+1, beat_cnt <= 0.
  - A forced rotation does not end the packet for the requester. Its remaining beats re-arbitrate in IDLE.
- busy = (state == BURST).
- Simultaneous events:
  - full rising in the same cycle as an accepted beat has no effect on that beat, because acceptance uses the current full.
  - rr_ptr wraps modulo NUM_REQ.
- At most one gnt bit is high in any cycle (one-hot or zero).

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined:
  - adds output stat_beats, NUM_REQ*CNT_WIDTH, one counter per requester
  - counter i increments on each accepted beat of requester i and saturates at all-ones
  - counters clear on wrst_n and on a new input stat_clr (1 cycle pulse, takes priority over an increment)
- Undefined: the ports and counters do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_t enum {IDLE, BURST}
  - helper function for the wrap-around increment
  - localparam for the id width ($clog2(NUM_REQ))
- Sub-module rr_pick: combinational round-robin picker.
  - inputs: req vector, rr_ptr
  - outputs: one-hot grant, winner index, any_req
- Instantiate rr_pick once.

Test Plan:
- Reset mid-burst: req0 bursting with beat_cnt = 2, pull wrst_n low -> gnt = 0, we = 0 and busy = 0 immediately; after release, next winner is searched from rr_ptr = 0.
- Round-robin: req0 and req1 both high with req_last = 1 on every beat, 4 cycles, full = 0 -> winners 0,1,0,1; data_in matches each requester's data; exactly one gnt per cycle.
- Packet lock: req2 sends 3 beats with req_last on beat 3 while req1 is high throughout -> gnt[2] for 3 accepted beats, busy = 1 for beats 2-3, req1 granted on the 4th cycle.
- Forced rotation: MAX_BURST = 4, req0 sends a 6-beat packet and req3 is waiting -> 4 beats from req0, then req3's packet, then req0's beats 5-6.
- Full stall: full = 1 for 3 cycles mid-burst -> we = 0 and gnt = 0 for those cycles, beat_cnt and owner unchanged, resume with no lost or duplicated beat.
- With FIFO_ARB_STATS_EN: 10 beats from req1 -> stat_beats[1] = 10; stat_clr pulse -> 0; with CNT_WIDTH = 2, 5 beats saturate at 3.
